// File: rtl/seq_checker.sv
// seq_checker: receive-side identifier for the integer-sequence generator bank.
// Tracks all eight known sequences (mod 256) in parallel against an incoming
// 8-bit sample stream. It drops candidates that mismatch and locks onto the
// single survivor once LOCK_LEN samples have been accepted.
//
// Ports:
//   clk        - clock
//   rst_n      - synchronous active-low reset
//   restart    - synchronous restart pulse, returns to IDLE (wins over in_valid)
//   in_valid   - sample strobe
//   in_data    - 8-bit sample value
//   alive      - candidate mask, bit i = sequence ID i still consistent
//   locked     - exactly one candidate left and sample_cnt >= LOCK_LEN
//   seq_id     - ID of the locked candidate (holds after a break)
//   fail       - all candidates eliminated, or the locked sequence broke
//   sample_cnt - accepted samples since restart, saturating at 255
//   exp_next   - predicted next sample while locked (SEQCHK_PREDICT_EN only)
//
// Build option: define SEQCHK_PREDICT_EN to build the exp_next predictor.
// Without it, exp_next is tied to zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no sample seen since reset/restart
// S_TRACK  | eliminating candidates; more than one left, or too few samples
// S_LOCKED | single candidate identified; only that one is checked
// S_FAIL   | no consistent candidate; samples ignored until restart/reset
module seq_checker #(
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic [7:0] alive,
  output logic       locked,
  output logic [2:0] seq_id,
  output logic       fail,
  output logic [7:0] sample_cnt,
  output logic [7:0] exp_next
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED, S_FAIL} state_e;

  localparam logic [7:0] LOCK_LEN_C = 8'(LOCK_LEN);

  state_e     state_q, state_d;
  logic [7:0] alive_q, alive_d;
  logic [2:0] seq_id_q, seq_id_d;
  logic [7:0] cnt_q, cnt_d;

  // Recurrence state. n_q is the shared term index for SQR and TRI.
  logic [7:0] n_q, sq_q, e3_q, tri_q;
  logic [7:0] fa_q, fb_q, pa_q, pb_q, la_q, lb_q;
  logic [7:0] da_q, db_q, dc_q, sy_q;

  logic [7:0] exp_cur [8];
  logic [7:0] exp_adv [8];
  logic [7:0] sy_m1, sy_prod;
  logic [7:0] match, alive_new, cnt_new;
  logic [2:0] idx_new;
  logic       onehot_new, accept;

  assign accept = in_valid && (state_q != S_FAIL);

  // Current expected term of each candidate.
  assign exp_cur[0] = sq_q;
  assign exp_cur[1] = e3_q;
  assign exp_cur[2] = tri_q;
  assign exp_cur[3] = fa_q;
  assign exp_cur[4] = pa_q;
  assign exp_cur[5] = la_q;
  assign exp_cur[6] = da_q;
  assign exp_cur[7] = sy_q;

  // Term after advancing by one sample; squares and triangles are built
  // incrementally so no wide multiplier is needed for them.
  assign sy_m1      = sy_q - 8'd1;
  assign sy_prod    = sy_q * sy_m1;
  assign exp_adv[0] = sq_q + {n_q[6:0], 1'b1};
  assign exp_adv[1] = e3_q + {e3_q[6:0], 1'b0};
  assign exp_adv[2] = tri_q + n_q + 8'd1;
  assign exp_adv[3] = fb_q;
  assign exp_adv[4] = pb_q;
  assign exp_adv[5] = lb_q;
  assign exp_adv[6] = db_q;
  assign exp_adv[7] = sy_prod + 8'd1;

  always_comb begin
    match   = '0;
    idx_new = '0;
    for (int i = 0; i < 8; i++) begin
      match[i] = (in_data == exp_cur[i]);
    end
    alive_new  = alive_q & match;
    onehot_new = (alive_new != 8'h00) && ((alive_new & (alive_new - 8'd1)) == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (alive_new[i]) idx_new = 3'(i);
    end
    cnt_new = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state_q  <= S_IDLE;
      alive_q  <= 8'hFF;
      seq_id_q <= '0;
      cnt_q    <= '0;
      n_q      <= 8'd0;
      sq_q     <= 8'd0;
      e3_q     <= 8'd1;
      tri_q    <= 8'd0;
      fa_q     <= 8'd1;
      fb_q     <= 8'd1;
      pa_q     <= 8'd0;
      pb_q     <= 8'd1;
      la_q     <= 8'd2;
      lb_q     <= 8'd1;
      da_q     <= 8'd1;
      db_q     <= 8'd1;
      dc_q     <= 8'd1;
      sy_q     <= 8'd2;
    end else begin
      state_q  <= state_d;
      alive_q  <= alive_d;
      seq_id_q <= seq_id_d;
      cnt_q    <= cnt_d;
      if (accept) begin
        n_q   <= n_q + 8'd1;
        sq_q  <= exp_adv[0];
        e3_q  <= exp_adv[1];
        tri_q <= exp_adv[2];
        fa_q  <= fb_q;
        fb_q  <= fa_q + fb_q;
        pa_q  <= pb_q;
        pb_q  <= {pb_q[6:0], 1'b0} + pa_q;
        la_q  <= lb_q;
        lb_q  <= la_q + lb_q;
        da_q  <= db_q;
        db_q  <= dc_q;
        dc_q  <= da_q + db_q;
        sy_q  <= exp_adv[7];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    alive_d  = alive_q;
    seq_id_d = seq_id_q;
    cnt_d    = cnt_q;
    if (accept) begin
      cnt_d = cnt_new;
      unique case (state_q)
        S_IDLE, S_TRACK: begin
          alive_d = alive_new;
          if (alive_new == 8'h00) begin
            state_d = S_FAIL;
          end else if (onehot_new && (cnt_new >= LOCK_LEN_C)) begin
            state_d  = S_LOCKED;
            seq_id_d = idx_new;
          end else begin
            state_d = S_TRACK;
          end
        end
        S_LOCKED: begin
          if (!match[seq_id_q]) begin
            state_d = S_FAIL;
            alive_d = 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    alive      = alive_q;
    seq_id     = seq_id_q;
    sample_cnt = cnt_q;
    locked     = (state_q == S_LOCKED);
    fail       = (state_q == S_FAIL);
  end

`ifdef SEQCHK_PREDICT_EN
  logic [7:0] exp_q, exp_d;

  // Updated alongside locked: the advanced term of the chosen candidate is
  // exactly the value expected on the next sample.
  always_comb begin
    exp_d = exp_q;
    if (accept) begin
      exp_d = (state_d == S_LOCKED) ? exp_adv[seq_id_d] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) exp_q <= 8'h00;
    else                   exp_q <= exp_d;
  end

  assign exp_next = exp_q;
`else
  assign exp_next = 8'h00;
`endif

endmodule
